// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered digit store.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
//
// state  | meaning
// GUARD  | anti-ghosting gap at slot start, all digit enables off
// SHOW   | current slot's digit enabled (unless blanked/suppressed)
module seg7_scan_ctrl #(
    parameter int NDIGITS = 4,
    parameter int DWELL   = 50000,
    parameter int GUARD   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(NDIGITS)-1:0] wr_idx,
    input  logic [3:0]                 wr_num,
    input  logic                       wr_dp,
    input  logic                       commit,
    input  logic                       blank,
    output logic [3:0]                 num,
    output logic                       dp_n,
    output logic [NDIGITS-1:0]         digit_sel
);

    localparam int IW = $clog2(NDIGITS);
    localparam int CW = $clog2(DWELL);
    localparam logic [IW:0]        NDIG_W = (IW+1)'(NDIGITS);
    localparam logic [NDIGITS-1:0] ONE_HOT0 = NDIGITS'(1);

    typedef enum logic {ST_GUARD, ST_SHOW} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic                pending, pending_nxt;
    logic                slot_end, frame_end, wr_fire, lz_sup;
    logic [NDIGITS-1:0]  sel_nxt;

    logic [3:0]          sh_num  [NDIGITS];
    logic [3:0]          act_num [NDIGITS];
    logic [NDIGITS-1:0]  sh_dp, act_dp;

    assign wr_ready = ~pending;

    always_comb begin
        slot_end    = (cnt == CW'(DWELL-1));
        frame_end   = slot_end && (idx == IW'(NDIGITS-1));
        cnt_nxt     = slot_end ? '0 : cnt + CW'(1);
        idx_nxt     = idx;
        state_nxt   = state;
        pending_nxt = pending;
        sel_nxt     = '0;
        wr_fire     = wr_valid && wr_ready && ({1'b0, wr_idx} < NDIG_W);

        if (slot_end)
            idx_nxt = frame_end ? '0 : idx + IW'(1);

        case (state)
            ST_GUARD: if (cnt == CW'(GUARD-1)) state_nxt = ST_SHOW;
            ST_SHOW:  if (slot_end)            state_nxt = ST_GUARD;
            default:                           state_nxt = ST_GUARD;
        endcase

        // Copy wins over a new commit: a commit while pending is ignored.
        if (pending && frame_end)
            pending_nxt = 1'b0;
        else if (commit && !pending)
            pending_nxt = 1'b1;

        if (state == ST_SHOW && !blank && !lz_sup)
            sel_nxt = ONE_HOT0 << idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_GUARD;
            cnt     <= '0;
            idx     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NDIGITS; i++) begin
                sh_num[i]  <= '0;
                act_num[i] <= '0;
            end
            sh_dp  <= '0;
            act_dp <= '0;
        end else begin
            if (wr_fire) begin
                sh_num[wr_idx] <= wr_num;
                sh_dp[wr_idx]  <= wr_dp;
            end
            // Whole-bank copy so a frame never mixes old and new digits.
            if (pending && frame_end) begin
                for (int i = 0; i < NDIGITS; i++)
                    act_num[i] <= sh_num[i];
                act_dp <= sh_dp;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_sel <= '0;
            num       <= '0;
            dp_n      <= 1'b1;
        end else begin
            digit_sel <= sel_nxt;
            if (cnt == '0) begin
                num  <= act_num[idx];
                dp_n <= ~act_dp[idx];
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [NDIGITS-1:0] zero_from;

    // zero_from[k]: slots k..NDIGITS-1 all hold 0 with no decimal point.
    always_comb begin
        zero_from = '0;
        zero_from[NDIGITS-1] = (act_num[NDIGITS-1] == 4'd0) && !act_dp[NDIGITS-1];
        for (int k = NDIGITS-2; k >= 0; k--)
            zero_from[k] = zero_from[k+1] && (act_num[k] == 4'd0) && !act_dp[k];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lz_sup <= 1'b0;
        else if (cnt == '0)
            lz_sup <= (idx != '0) && zero_from[idx];
    end
`else
    assign lz_sup = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIGITS=4, DWELL=8, GUARD=2.
// Expected digit enables follow SEG7_LZ_BLANK_EN when it is defined.
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset, wr_valid, wr_ready, wr_dp, commit, blank, dp_n;
    logic [1:0] wr_idx;
    logic [3:0] wr_num, num, digit_sel;

    int t, n_vec, n_bad, hi, lit;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NDIGITS(4), .DWELL(8), .GUARD(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_idx    (wr_idx),
        .wr_num    (wr_num),
        .wr_dp     (wr_dp),
        .commit    (commit),
        .blank     (blank),
        .num       (num),
        .dp_n      (dp_n),
        .digit_sel (digit_sel)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // t counts rising edges since reset release; sampling is 1 ns after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    task automatic go_to(input int target);
        if (target > t) tick(target - t);
    endtask

    task automatic do_write(input logic [1:0] i, input logic [3:0] v, input logic d);
        wr_valid = 1'b1;
        wr_idx   = i;
        wr_num   = v;
        wr_dp    = d;
        tick(1);
        wr_valid = 1'b0;
    endtask

    // Mid-show sample of slot k in frame f (cnt=4 in the cycle before the sample).
    task automatic check_slot(input string tag, input int f, input int k,
                              input logic [3:0] e_sel, input logic [3:0] e_num, input logic e_dpn);
        go_to(32*f + 8*k + 5);
        check_val($sformatf("%s_sel%0d", tag, k), digit_sel, e_sel);
        check_val($sformatf("%s_num%0d", tag, k), num, e_num);
        check_val($sformatf("%s_dpn%0d", tag, k), dp_n, e_dpn);
    endtask

    logic lz;

    initial begin
`ifdef SEG7_LZ_BLANK_EN
        lz = 1'b1;
`else
        lz = 1'b0;
`endif
        n_vec = 0; n_bad = 0; t = 0;
        reset = 1'b1; wr_valid = 1'b0; commit = 1'b0; blank = 1'b0;
        wr_idx = '0; wr_num = '0; wr_dp = 1'b0;
        tick(3);
        check_val("rst_sel",   digit_sel, 4'b0000);
        check_val("rst_num",   num,       4'h0);
        check_val("rst_dpn",   dp_n,      1'b1);
        check_val("rst_ready", wr_ready,  1'b1);

        // Slot 0 enable: rises 3 edges after release, high for 6 cycles.
        reset = 1'b0; t = 0; hi = 0;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            if (t == 2) check_val("t2_sel", digit_sel, 4'b0000);
            if (t == 3) check_val("t3_sel", digit_sel, 4'b0001);
            if (t == 9) check_val("t9_sel", digit_sel, 4'b0000);
            if (digit_sel != 4'b0000) hi++;
        end
        check_val("slot0_high", hi, 6);

        // Fill shadow 1,2,3,4 with dp on idx2, then commit.
        go_to(12);
        do_write(2'd0, 4'h1, 1'b0);
        do_write(2'd1, 4'h2, 1'b0);
        do_write(2'd2, 4'h3, 1'b1);
        do_write(2'd3, 4'h4, 1'b0);
        commit = 1'b1; tick(1); commit = 1'b0;
        check_val("commit_ready", wr_ready, 1'b0);
        go_to(20);
        do_write(2'd0, 4'h9, 1'b1);          // dropped: wr_ready is low
        go_to(29);
        check_val("precommit_num", num, 4'h0);
        go_to(31);
        check_val("pend_ready", wr_ready, 1'b0);
        go_to(33);
        check_val("post_ready", wr_ready, 1'b1);
        for (int k = 0; k < 4; k++)
            check_slot("frm1", 1, k, 4'(1 << k), 4'(k + 1), (k == 2) ? 1'b0 : 1'b1);

        // Uncommitted write stays invisible.
        go_to(66);
        do_write(2'd1, 4'h7, 1'b0);
        for (int f = 2; f <= 4; f++)
            check_slot($sformatf("hold%0d", f), f, 1, 4'b0010, 4'h2, 1'b1);

        // Write and commit in the same cycle.
        go_to(165);
        wr_valid = 1'b1; wr_idx = 2'd3; wr_num = 4'hA; wr_dp = 1'b0; commit = 1'b1;
        tick(1);
        wr_valid = 1'b0; commit = 1'b0;
        check_val("wc_ready", wr_ready, 1'b0);
        check_slot("frm6", 6, 0, 4'b0001, 4'h1, 1'b1);
        check_slot("frm6", 6, 1, 4'b0010, 4'h7, 1'b1);
        check_slot("frm6", 6, 2, 4'b0100, 4'h3, 1'b0);
        check_slot("frm6", 6, 3, 4'b1000, 4'hA, 1'b1);

        // Blank for 20 cycles; num/dp_n keep scanning.
        go_to(230);
        blank = 1'b1; lit = 0;
        for (int e = 0; e < 20; e++) begin
            tick(1);
            if (digit_sel != 4'b0000) lit++;
            if (t == 241) begin
                check_val("blank_num", num, 4'h3);
                check_val("blank_dpn", dp_n, 1'b0);
            end
        end
        blank = 1'b0;
        check_val("blank_lit", lit, 0);
        go_to(253);
        check_val("unblank_sel", digit_sel, 4'b1000);
        check_val("unblank_num", num, 4'hA);
        go_to(261);
        check_val("wrap_sel", digit_sel, 4'b0001);
        check_val("wrap_num", num, 4'h1);

        // Reset mid-slot with a commit pending.
        go_to(266);
        commit = 1'b1; tick(1); commit = 1'b0;
        check_val("pend2_ready", wr_ready, 1'b0);
        go_to(270);
        check_val("prerst_sel", digit_sel, 4'b0010);
        reset = 1'b1;
        tick(1);
        check_val("mrst_sel",   digit_sel, 4'b0000);
        check_val("mrst_num",   num,       4'h0);
        check_val("mrst_dpn",   dp_n,      1'b1);
        check_val("mrst_ready", wr_ready,  1'b1);
        tick(1);
        reset = 1'b0; t = 0;
        go_to(2);
        check_val("mrst_t2_sel", digit_sel, 4'b0000);
        go_to(3);
        check_val("mrst_t3_sel", digit_sel, 4'b0001);

        // Active = {0,0,5,0} (idx3..0).
        go_to(4);
        do_write(2'd1, 4'h5, 1'b0);
        commit = 1'b1; tick(1); commit = 1'b0;
        check_slot("lz", 1, 0, 4'b0001, 4'h0, 1'b1);
        check_slot("lz", 1, 1, 4'b0010, 4'h5, 1'b1);
        check_slot("lz", 1, 2, lz ? 4'b0000 : 4'b0100, 4'h0, 1'b1);
        check_slot("lz", 1, 3, lz ? 4'b0000 : 4'b1000, 4'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing scan controller that shares one 4-bit-to-7-segment decoder across `NDIGITS` common-anode digits. It holds a double-buffered digit store written by requesters through a valid/ready port, and commits shadow contents atomically at frame boundaries. It steps through digits with a programmable dwell and anti-ghosting guard gap. It sits between the application logic and the decoder/pin drivers: `num` feeds the decoder, `digit_sel` drives the digit enables, and `dp_n` replaces decoder bit 7.

## Interface
- `NDIGITS`, default 4: number of multiplexed digits, 2..8.
- `DWELL`, default 50000: clock cycles per digit slot, must be greater than `GUARD`.
- `GUARD`, default 2: blank cycles at the start of each slot, must be ≥ 1.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `wr_valid`, input, 1: a write request is present.
- `wr_ready`, output, 1: the shadow store can accept a write.
- `wr_idx`, input, $clog2(NDIGITS): target digit; index 0 is the least-significant digit.
- `wr_num`, input, 4: hex value to store.
- `wr_dp`, input, 1: decimal point for that digit (1 = lit).
- `commit`, input, 1: single-cycle request to copy shadow to active at the next frame boundary.
- `blank`, input, 1: forces all digits off while high.
- `num`, output, 4: value for the decoder, registered.
- `dp_n`, output, 1: active-low decimal point, registered.
- `digit_sel`, output, NDIGITS: one-hot, active-high digit enable, registered.

## Operation
- **Storage.** The shadow and active banks each hold `NDIGITS` × {num[3:0], dp}.
- **Write acceptance.** A write is accepted when `wr_valid && wr_ready`: `shadow[wr_idx]` is updated on that edge. Writes with `wr_ready` = 0 are dropped, and the requester must hold them until accepted. A `wr_idx` ≥ `NDIGITS` is accepted and discarded.
- **Commit.** A `commit` while `wr_ready` = 1 sets `pending` and drops `wr_ready` on the next cycle. A `commit` while `pending` is already set is ignored.
  - At the frame boundary (slot `NDIGITS-1` → slot 0 transition), active ← shadow, all digits at once, and `pending` clears.
  - `wr_ready` returns to 1 on the cycle after the copy.
- **Same-cycle write and commit.** The write is applied first and is included in the commit.
- **Scan counters.** `cnt` counts 0..`DWELL-1`. At `DWELL-1` it wraps to 0 and `idx` advances; `idx` wraps from `NDIGITS-1` to 0.
- **Slot phases.**
  - Guard phase, `cnt` < `GUARD`: `digit_sel` = 0.
  - Show phase: `digit_sel` = one-hot(`idx`) unless `blank` = 1.
  - `num` and `dp_n` load from `active[idx]` at `cnt` = 0, so they are stable before the enable rises.
- **State machine.** States are GUARD and SHOW.
  - GUARD→SHOW when `cnt` = `GUARD-1`.
  - SHOW→GUARD when `cnt` = `DWELL-1`.
  - Reset enters GUARD.
- **Reset values.** Reset is honoured at any point, including mid-slot or with a commit pending.
  - `idx`=0, `cnt`=0, `pending`=0, all bank entries 0 with dp=0.
  - `digit_sel`=0, `num`=0, `dp_n`=1, `wr_ready`=1.
  - A pending commit is lost.

## Timing
- **Registered outputs.** All outputs update one cycle after the `cnt`/`idx`/state condition that produces them.
- **`digit_sel` high time.** Exactly `DWELL-GUARD` cycles per slot. The frame period is `NDIGITS`×`DWELL` cycles.
- **Write latency.** Writes are not visible on the display until committed. Committed latency is from 1 cycle up to one frame plus 1 cycle.
- **`blank` timing.** `blank` takes effect on `digit_sel` one cycle after it is asserted. Scanning continues while blanked, and `num`/`dp_n` keep updating.
- **Write throughput.** One write per cycle while not pending.

## Configuration
- Macro: `SEG7_LZ_BLANK_EN`.
- **Defined (leading-zero blanking).**
  - A slot `k` ≥ 1 is suppressed (`digit_sel` stays 0 for that slot) when active `num` = 0 and `dp` = 0 for slot `k` and for every slot above `k`.
  - Slot 0 is never suppressed.
  - Suppression is evaluated from the active bank at `cnt` = 0 of the slot.
- **Undefined.** All slots are always shown.

## Test plan
- **Reset.** With `NDIGITS`=4, `DWELL`=8, `GUARD`=2, assert `reset` mid-slot → next cycle `digit_sel`=0, `num`=0, `dp_n`=1, `wr_ready`=1. After release, slot 0 enables 3 cycles later (2 guard cycles plus 1 register cycle) and stays high for 6 cycles.
- **Write and commit.** Write idx0..3 = 1, 2, 3, 4 with dp on idx2, then `commit` → `wr_ready`=0 until the frame boundary. The next frame shows `num` 1, 2, 3, 4 in slots 0..3, with `dp_n`=0 only in slot 2.
- **Write before commit.** A write without `commit` → display unchanged for ≥ 3 frames.
- **Handshake corner cases.** A write with `wr_ready`=0 → shadow unchanged after the boundary. A write and `commit` in the same cycle → the written value appears in the committed frame.
- **Blank.** Assert `blank` for 20 cycles → `digit_sel`=0 throughout, and `idx` continues advancing. On release, scanning resumes in the correct slot.
- **Leading-zero blanking.** With `SEG7_LZ_BLANK_EN` defined and active = {0, 0, 5, 0} (idx3..0) → slots 3 and 2 dark, slots 1 and 0 lit. With the macro undefined → all 4 slots lit.
